video_timing_gen: RTL
=====================

# video_timing_gen

Parametrised raster timing generator for the DVI/VGA output path. Produces HS/VS/DE, active-area pixel coordinates, a linear framebuffer address, and integer-scaled window coordinates for a centred source image (Game Boy 160×144 at ×3 by default). Optionally frame-locks to an upstream vertical-sync pulse. Sits between the system clock domain's pixel clock and the TMDS encoder / framebuffer read port.

## Interface
- H_ACT, 640, active pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths
- V_ACT, 480, active lines
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths (lines)
- HS_POL / VS_POL, 0 / 0, asserted sync level (0 = active-low)
- SCALE, 3, integer upscale factor, ≥1
- WIN_W / WIN_H, 160 / 144, source window size; WIN_W·SCALE ≤ H_ACT, WIN_H·SCALE ≤ V_ACT
- CW, 11, coordinate width; ADDR_W, 20, address width
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-low reset
- vsi  in  1  upstream frame-start request (synchronous to clk)
- hs, vs  out  1  sync outputs at configured polarity
- de  out  1  active-video enable
- x, y  out  CW  active-area coordinates; 0 outside active area
- win_en  out  1  pixel inside scaled window
- win_x, win_y  out  8  source coordinates; 0 when win_en low
- address  out  ADDR_W  y·H_ACT + x
- frame_start  out  1  one-cycle pulse at first active pixel of each frame
- resync  out  1  one-cycle pulse when vsi forced a counter correction

## Operation
- H_TOTAL = H_ACT+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Derived constants: WX0 = (H_ACT − WIN_W·SCALE)/2, WY0 = (V_ACT − WIN_H·SCALE)/2 (floor).
- h_cnt runs 0..H_TOTAL−1, wraps to 0; v_cnt increments on h wrap, runs 0..V_TOTAL−1, wraps to 0.
- Line order: active (h_cnt < H_ACT), front porch, sync, back porch. Same for frame in lines.
- hs asserted for h_cnt ∈ [H_ACT+H_FRONT, H_ACT+H_FRONT+H_SYNC). vs asserted for v_cnt ∈ [V_ACT+V_FRONT, V_ACT+V_FRONT+V_SYNC), whole lines.
- de = (h_cnt < H_ACT) && (v_cnt < V_ACT).
- Scaling: sub-pixel counters hs_div, vs_div count 0..SCALE−1 inside window span; win_x increments when hs_div wraps, restarts at 0 at WX0 each line; win_y likewise per line at WY0, restarting each frame. No multipliers/dividers for window coordinates.
- address computed with a running accumulator (+1 per active pixel, line base += H_ACT); no multiplier.
- Frame lock (see Configuration): rising edge of vsi (vsi high, registered previous value low) forces h_cnt=0, v_cnt=0 and all divider/window counters to 0 on the next clock. resync pulses if counters were not already about to wrap to (0,0); otherwise the edge is a no-op and resync stays low.

## Timing
- All outputs registered: outputs at cycle t reflect counter state at t−1 (latency 1).
- Reset (rst low at a clk edge): counters 0; hs = ~HS_POL, vs = ~VS_POL, de/win_en/frame_start/resync 0, x/y/win_x/win_y/address 0. First de high on the second clock after rst deasserts.
- frame_start coincides with de for pixel (0,0).
- vsi edge and natural wrap on same cycle: wrap wins, resync 0.
- vsi held high: only one correction per rising edge.
- rst dominates vsi.

## Configuration
- VIDEO_TIMING_LOCK_EN defined: vsi edge detector and resync logic compiled in as above.
- Undefined: vsi ignored (port kept), resync tied 0, generator free-runs.

## Structure
- Shared package video_pkg: default timing constants for 640×480@60, GB window size, derived H_TOTAL/V_TOTAL/WX0/WY0 functions.
- One sub-module: video_axis_counter (count, porch/sync decode, scale divider), instantiated once for H and once for V with enable = h wrap.

## Test plan
- Defaults, free run 2 frames -> line period 800 clk, frame 420000 clk; hs low 96 clk starting h_cnt 656; vs low lines 490–491.
- Defaults -> win_en first high at x=80, y=24; win_x increments every 3 pixels, 159 at x=557–559; win_y=143 at y=453–455; win_en low at x=560.
- address at x=639,y=479 -> 307199; de count per frame 307200; frame_start once per frame.
- LOCK_EN, vsi pulse at h_cnt=300,v_cnt=100 -> two cycles later de=1, x=0, y=0, resync=1 for one cycle; vsi at natural wrap -> resync 0.
- HS_POL=1, VS_POL=1, SCALE=2, H_ACT=320 -> sync polarities inverted, WX0=0, win_x steps every 2 pixels.
- rst low mid-line for one clk -> all outputs at reset values next cycle, timing restarts from (0,0).

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: default 640x480@60 raster timing, Game Boy window size and derived-constant helpers.
package video_pkg;
    localparam int H_ACT_D   = 640;
    localparam int H_FRONT_D = 16;
    localparam int H_SYNC_D  = 96;
    localparam int H_BACK_D  = 48;
    localparam int V_ACT_D   = 480;
    localparam int V_FRONT_D = 10;
    localparam int V_SYNC_D  = 2;
    localparam int V_BACK_D  = 33;
    localparam int SCALE_D   = 3;
    localparam int WIN_W_D   = 160;
    localparam int WIN_H_D   = 144;

    function automatic int axis_total(input int act, input int front, input int sync, input int back);
        return act + front + sync + back;
    endfunction

    function automatic int win_start(input int act, input int win, input int scale);
        return (act - win * scale) / 2;
    endfunction
endpackage

// File: rtl/video_axis_counter.sv
// video_axis_counter: one raster axis - position counter, sync/active decode and integer-scale window divider.
module video_axis_counter
    import video_pkg::*;
#(
    parameter int ACT   = H_ACT_D,
    parameter int FRONT = H_FRONT_D,
    parameter int SYNC  = H_SYNC_D,
    parameter int BACK  = H_BACK_D,
    parameter int SCALE = SCALE_D,
    parameter int WIN   = WIN_W_D,
    parameter int CW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          act,
    output logic          sync,
    output logic          in_win,
    output logic [7:0]    win
);
    localparam int TOTAL = axis_total(ACT, FRONT, SYNC, BACK);
    localparam int W0    = win_start(ACT, WIN, SCALE);

    logic [CW-1:0] div;

    assign wrap   = en && cnt == CW'(TOTAL - 1);
    assign act    = cnt < CW'(ACT);
    // Unsigned wrap-around turns each range test into a single compare.
    assign sync   = cnt - CW'(ACT + FRONT) < CW'(SYNC);
    assign in_win = cnt - CW'(W0) < CW'(WIN * SCALE);

    always_ff @(posedge clk) begin
        if (!rst || clr || wrap) begin
            cnt <= '0;
            div <= '0;
            win <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
            if (in_win) begin
                div <= div == CW'(SCALE - 1) ? '0 : div + 1'b1;
                win <= div == CW'(SCALE - 1) ? win + 1'b1 : win;
            end
        end
    end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with scaled-window coordinates and framebuffer address.
// Define VIDEO_TIMING_LOCK_EN to frame-lock the counters to rising edges of vsi.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACT   = H_ACT_D,
    parameter int H_FRONT = H_FRONT_D,
    parameter int H_SYNC  = H_SYNC_D,
    parameter int H_BACK  = H_BACK_D,
    parameter int V_ACT   = V_ACT_D,
    parameter int V_FRONT = V_FRONT_D,
    parameter int V_SYNC  = V_SYNC_D,
    parameter int V_BACK  = V_BACK_D,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int SCALE   = SCALE_D,
    parameter int WIN_W   = WIN_W_D,
    parameter int WIN_H   = WIN_H_D,
    parameter int CW      = 11,
    parameter int ADDR_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsi,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic [CW-1:0]     x,
    output logic [CW-1:0]     y,
    output logic              win_en,
    output logic [7:0]        win_x,
    output logic [7:0]        win_y,
    output logic [ADDR_W-1:0] address,
    output logic              frame_start,
    output logic              resync
);
    logic [CW-1:0]     h_cnt, v_cnt;
    logic              h_wrap, v_wrap, h_act, v_act, h_sync, v_sync, h_win, v_win;
    logic [7:0]        h_w, v_w;
    logic [ADDR_W-1:0] acc;
    logic              clr, resync_p, de_c, win_c;

    video_axis_counter #(.ACT(H_ACT), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
                         .SCALE(SCALE), .WIN(WIN_W), .CW(CW)) u_h (
        .clk(clk), .rst(rst), .en(1'b1), .clr(clr), .cnt(h_cnt), .wrap(h_wrap),
        .act(h_act), .sync(h_sync), .in_win(h_win), .win(h_w)
    );

    video_axis_counter #(.ACT(V_ACT), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
                         .SCALE(SCALE), .WIN(WIN_H), .CW(CW)) u_v (
        .clk(clk), .rst(rst), .en(h_wrap), .clr(clr), .cnt(v_cnt), .wrap(v_wrap),
        .act(v_act), .sync(v_sync), .in_win(v_win), .win(v_w)
    );

`ifdef VIDEO_TIMING_LOCK_EN
    logic vsi_q;
    assign clr = vsi && !vsi_q;
    // An edge landing on the natural (0,0) wrap changes nothing, so it is not reported.
    always_ff @(posedge clk) begin
        vsi_q    <= vsi;
        resync_p <= rst && clr && !(h_wrap && v_wrap);
    end
`else
    logic unused_vsi;
    assign unused_vsi = vsi;
    assign clr        = 1'b0;
    assign resync_p   = 1'b0;
`endif

    assign de_c  = h_act && v_act;
    assign win_c = de_c && h_win && v_win;

    always_ff @(posedge clk) begin
        if (!rst || clr || (h_wrap && v_wrap))
            acc <= '0;
        else if (de_c)
            acc <= acc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hs          <= !HS_POL;
            vs          <= !VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            win_en      <= 1'b0;
            win_x       <= '0;
            win_y       <= '0;
            address     <= '0;
            frame_start <= 1'b0;
            resync      <= 1'b0;
        end else begin
            hs          <= h_sync ^ !HS_POL;
            vs          <= v_sync ^ !VS_POL;
            de          <= de_c;
            x           <= de_c ? h_cnt : '0;
            y           <= de_c ? v_cnt : '0;
            win_en      <= win_c;
            win_x       <= win_c ? h_w : '0;
            win_y       <= win_c ? v_w : '0;
            address     <= de_c ? acc : '0;
            frame_start <= h_cnt == '0 && v_cnt == '0;
            resync      <= resync_p;
        end
    end
endmodule
